// File: rtl/adder_tree_feeder.sv
// Packs a serial valid/ready word stream into NUM_LANES parallel lanes for the adder tree.
// Short groups closed by in_last are zero-padded; one fill bank plus one output bank.
module adder_tree_feeder #(
    parameter int ADDER_WIDTH = 32,
    parameter int NUM_LANES   = 8,
    parameter int IDX_W       = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDER_WIDTH-1:0]           in_data,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic [NUM_LANES*ADDER_WIDTH-1:0] lanes,
    output logic [IDX_W:0]                   out_count,
    output logic                             out_valid,
    input  logic                             out_ready
);

    typedef logic [NUM_LANES-1:0][ADDER_WIDTH-1:0] bank_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    bank_t            fill_q, fill_d, fill_wr;
    bank_t            lanes_q, lanes_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             pending_q, pending_d;
    logic             out_valid_q, out_valid_d;

    logic accept;
    logic complete;
    logic slot_free;
    logic launch;

    // Lanes beyond the last real word are forced to the additive identity.
    function automatic bank_t pad_group(input bank_t grp, input logic [IDX_W-1:0] last_idx);
        bank_t res;
        res = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            res[i] = (i <= int'(last_idx)) ? grp[i] : '0;
        end
        return res;
    endfunction

    assign in_ready  = !pending_q;
    assign accept    = in_valid && in_ready;
    assign complete  = accept && (in_last || (idx_q == LAST_IDX));
    assign slot_free = !out_valid_q || out_ready;
    // A held group has priority; no word can be accepted while one is pending.
    assign launch    = (pending_q && out_ready) || (complete && slot_free);

    always_comb begin
        fill_wr = fill_q;
        if (accept) begin
            fill_wr[idx_q] = in_data;
        end

        fill_d      = fill_wr;
        idx_d       = idx_q;
        pending_d   = pending_q;
        lanes_d     = lanes_q;
        count_d     = count_q;
        out_valid_d = out_valid_q && !out_ready;

        if (launch) begin
            lanes_d     = pad_group(fill_wr, idx_q);
            count_d     = {1'b0, idx_q} + (IDX_W + 1)'(1);
            out_valid_d = 1'b1;
            fill_d      = '0;
            idx_d       = '0;
            pending_d   = 1'b0;
        end else if (complete) begin
            // Output slot busy: keep the finished group in the fill bank, idx marks its last lane.
            pending_d = 1'b1;
        end else if (accept) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q      <= '0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            lanes_q     <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            lanes_q     <= lanes_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign lanes     = lanes_q;
    assign out_count = count_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Bench for adder_tree_feeder: vector table, directed multi-cycle corner cases and a
// randomized run checked against a transaction-level model of the group stream.
module tb_adder_tree_feeder;

    localparam int W = 32;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] lanes;
    logic [3:0]     out_count;
    logic           out_valid;
    logic           out_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    adder_tree_feeder #(.ADDER_WIDTH(W), .NUM_LANES(N), .IDX_W(3)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .lanes(lanes),
        .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, act=running exp=done");
        $fatal(1);
    end

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        ordy;
        logic        e_valid;
        logic        e_ready;
        logic [3:0]  e_count;
        logic [34:0] e_sum;
    } vec_t;

    typedef struct {
        logic [N*W-1:0] lanes;
        logic [3:0]     cnt;
    } grp_t;

    vec_t        tbl[$];
    grp_t        q_out[$];
    logic [31:0] cur[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [34:0] tree_sum(input logic [N*W-1:0] l);
        logic [34:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s = s + 35'(l[i*W +: W]);
        return s;
    endfunction

    function automatic void add(input logic v, input logic [31:0] d, input logic l,
                                input logic ordy, input logic ev, input logic er,
                                input logic [3:0] ec, input logic [34:0] es);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.ordy = ordy;
        r.e_valid = ev; r.e_ready = er; r.e_count = ec; r.e_sum = es;
        tbl.push_back(r);
    endfunction

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        q_out.delete();
        cur.delete();
    endtask

    // One cycle against the model: check outputs, drive inputs, predict the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic ordy);
        bit   acc, cons;
        grp_t g;
        @(negedge clk);
        chk("rnd_out_valid", out_valid, q_out.size() > 0);
        chk("rnd_in_ready", in_ready, q_out.size() < 2);
        if (q_out.size() > 0) begin
            chk("rnd_lanes", lanes, q_out[0].lanes);
            chk("rnd_count", out_count, q_out[0].cnt);
        end
        in_valid = v; in_data = d; in_last = l; out_ready = ordy;
        acc  = v && (q_out.size() < 2);
        cons = ordy && (q_out.size() > 0);
        if (cons) void'(q_out.pop_front());
        if (acc) begin
            cur.push_back(d);
            if (l || cur.size() == N) begin
                g.lanes = '0;
                for (int i = 0; i < cur.size(); i++) g.lanes[i*W +: W] = cur[i];
                g.cnt = 4'(cur.size());
                q_out.push_back(g);
                cur.delete();
            end
        end
    endtask

    initial begin
        logic [31:0]    w[16];
        logic [N*W-1:0] exp1, exp2;
        int             guard;

        // Streams 1..8, then 10,20,30 with last, then eight all-ones words.
        for (int i = 0; i < 8; i++)
            add(1, 32'(i + 1), 0, 1, i == 7, 1, (i == 7) ? 4'd8 : 4'd0, (i == 7) ? 35'd36 : 35'd0);
        add(0, 32'h0, 0, 1, 0, 1, 4'd8, 35'd36);
        add(1, 32'd10, 0, 1, 0, 1, 4'd8, 35'd36);
        add(1, 32'd20, 0, 1, 0, 1, 4'd8, 35'd36);
        add(1, 32'd30, 1, 1, 1, 1, 4'd3, 35'd60);
        add(0, 32'h0, 1, 1, 0, 1, 4'd3, 35'd60);
        for (int i = 0; i < 8; i++)
            add(1, 32'hFFFF_FFFF, 0, 1, i == 7, 1, (i == 7) ? 4'd8 : 4'd3,
                (i == 7) ? 35'h7_FFFF_FFF8 : 35'd60);
        add(0, 32'h0, 0, 1, 0, 1, 4'd8, 35'h7_FFFF_FFF8);

        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_lanes", lanes, 0);
        chk("reset_count", out_count, 0);
        chk("reset_in_ready", in_ready, 1);
        reset = 1'b0;

        foreach (tbl[k]) begin
            @(negedge clk);
            in_valid = tbl[k].v; in_data = tbl[k].d; in_last = tbl[k].l; out_ready = tbl[k].ordy;
            @(posedge clk);
            #1;
            chk("tbl_out_valid", out_valid, tbl[k].e_valid);
            chk("tbl_in_ready", in_ready, tbl[k].e_ready);
            chk("tbl_count", out_count, tbl[k].e_count);
            chk("tbl_tree_sum", tree_sum(lanes), tbl[k].e_sum);
        end

        // Backpressure: two full groups with the output stalled.
        reset_pulse();
        exp1 = '0; exp2 = '0;
        for (int i = 0; i < 16; i++) begin
            w[i] = $urandom;
            if (i < 8) exp1[i*W +: W] = w[i];
            else       exp2[(i-8)*W +: W] = w[i];
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1; in_data = w[i]; in_last = 0; out_ready = 0;
            @(posedge clk);
            #1;
            chk("bp_in_ready", in_ready, i < 15);
            if (i >= 7) begin
                chk("bp_out_valid", out_valid, 1);
                chk("bp_lanes_stable", lanes, exp1);
                chk("bp_count", out_count, 8);
            end
        end
        @(negedge clk);
        in_data = 32'hDEAD;
        @(posedge clk);
        #1;
        chk("bp_held_in_ready", in_ready, 0);
        chk("bp_held_lanes", lanes, exp1);
        @(negedge clk);
        in_valid = 0; out_ready = 1;
        @(posedge clk);
        #1;
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_lanes", lanes, exp2);
        chk("bp_second_count", out_count, 8);
        chk("bp_release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("bp_drained_valid", out_valid, 0);
        chk("bp_drained_in_ready", in_ready, 1);
        chk("bp_drained_lanes_hold", lanes, exp2);

        // Reset in the middle of a group discards it.
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1; in_data = 32'(i + 1); in_last = 0; out_ready = 1;
        end
        @(negedge clk);
        in_valid = 0;
        reset = 1'b1;
        #2;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_lanes", lanes, 0);
        chk("midrst_count", out_count, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1; in_data = 32'hA; in_last = 1;
        @(posedge clk);
        #1;
        chk("midrst_lane0", lanes, 256'hA);
        chk("midrst_one_lane_count", out_count, 1);
        chk("midrst_one_lane_valid", out_valid, 1);

        // Randomized run against the transaction model, starting with a continuous stream.
        reset_pulse();
        for (int i = 0; i < 64; i++) step(1, $urandom, 0, 1);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) < 6);
        guard = 0;
        while ((q_out.size() > 0 || cur.size() > 0) && guard < 40) begin
            step(cur.size() > 0, $urandom, 1, 1);
            guard++;
        end
        chk("rnd_drain_done", guard < 40, 1);
        step(0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
